// File: rtl/bpsk_sym_map.sv
// BPSK symbol mapper: elastic bit FIFO, optional differential
// encoder and a hold upsampler that emits SPS samples per bit.
module bpsk_sym_map #(
  parameter int SPS     = 8,
  parameter int OW      = 16,
  parameter int AMP     = 8191,
  parameter int DEPTH   = 16,
  parameter int DIFF_EN = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       data_in,
  input  logic                       data_vld,
  input  logic                       en,
  input  logic                       clr_flags,
  output logic [OW-1:0]              sample_out,
  output logic                       sample_vld,
  output logic                       bit_strobe,
  output logic [$clog2(DEPTH):0]     fifo_level,
  output logic                       overflow,
  output logic                       underrun
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(SPS);

  localparam logic signed [OW-1:0] POS = OW'(AMP);
  localparam logic signed [OW-1:0] NEG = -POS;

  typedef enum logic {
    PRIME = 1'b0,
    RUN   = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [DEPTH-1:0] mem_q, mem_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            d_prev_q, d_prev_d;
  logic [OW-1:0]   sym_q, sym_d;
  logic [OW-1:0]   sample_out_q, sample_out_d;
  logic            sample_vld_q, sample_vld_d;
  logic            bit_strobe_q, bit_strobe_d;
  logic            ovf_q, ovf_d;
  logic            udr_q, udr_d;

  logic pop;
  logic wr_ok;
  logic full;
  logic udr_set;
  logic fifo_bit;
  logic d_bit;

  assign full = (level_q == LW'(DEPTH));

  always_comb begin
    state_d      = state_q;
    mem_d        = mem_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    cnt_d        = cnt_q;
    d_prev_d     = d_prev_q;
    sym_d        = sym_q;
    sample_out_d = sample_out_q;
    sample_vld_d = 1'b0;
    bit_strobe_d = 1'b0;
    pop          = 1'b0;
    udr_set      = 1'b0;
    fifo_bit     = mem_q[rd_ptr_q];
    d_bit        = 1'b0;

    unique case (state_q)
      PRIME: begin
        cnt_d        = '0;
        sample_out_d = '0;
        if (level_q >= LW'(DEPTH / 2)) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (en) begin
          if (cnt_q == '0) begin
            // A bit boundary with nothing buffered drops back to priming.
            if (level_q == '0) begin
              udr_set      = 1'b1;
              sample_out_d = '0;
              state_d      = PRIME;
            end else begin
              pop          = 1'b1;
              d_bit        = (DIFF_EN != 0) ?
                             (fifo_bit ^ d_prev_q) : fifo_bit;
              d_prev_d     = d_bit;
              sym_d        = d_bit ? NEG : POS;
              sample_out_d = sym_d;
              sample_vld_d = 1'b1;
              bit_strobe_d = 1'b1;
              cnt_d        = cnt_q + 1'b1;
            end
          end else begin
            sample_out_d = sym_q;
            sample_vld_d = 1'b1;
            cnt_d        = (cnt_q == CW'(SPS - 1)) ?
                           '0 : cnt_q + 1'b1;
          end
        end
      end
    endcase

    // A same-cycle pop frees the slot a full FIFO would refuse.
    wr_ok = data_vld && (!full || pop);
    if (wr_ok) begin
      mem_d[wr_ptr_q] = data_in;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    level_d = level_q + LW'(wr_ok) - LW'(pop);

    ovf_d = (ovf_q && !clr_flags) || (data_vld && !wr_ok);
    udr_d = (udr_q && !clr_flags) || udr_set;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= PRIME;
      mem_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      cnt_q        <= '0;
      d_prev_q     <= 1'b0;
      sym_q        <= '0;
      sample_out_q <= '0;
      sample_vld_q <= 1'b0;
      bit_strobe_q <= 1'b0;
      ovf_q        <= 1'b0;
      udr_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      cnt_q        <= cnt_d;
      d_prev_q     <= d_prev_d;
      sym_q        <= sym_d;
      sample_out_q <= sample_out_d;
      sample_vld_q <= sample_vld_d;
      bit_strobe_q <= bit_strobe_d;
      ovf_q        <= ovf_d;
      udr_q        <= udr_d;
    end
  end

  assign sample_out = sample_out_q;
  assign sample_vld = sample_vld_q;
  assign bit_strobe = bit_strobe_q;
  assign fifo_level = level_q;
  assign overflow   = ovf_q;
  assign underrun   = udr_q;

endmodule
